// File: rtl/dispensador_billetes.sv
// Bill-dispense sequencer: splits an order greedily into four denominations and
// hands bills to the cash mechanism one at a time over a READY/STB/ACK handshake.
module dispensador_billetes #(
  parameter int unsigned DENOM0    = 20000,
  parameter int unsigned DENOM1    = 10000,
  parameter int unsigned DENOM2    = 5000,
  parameter int unsigned DENOM3    = 1000,
  parameter int unsigned MAX_MONTO = 500000,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        entregar_dinero_i,
  input  logic [31:0] monto_i,
  input  logic        mech_ready_i,
  input  logic        mech_ack_i,
  output logic        billete_stb_o,
  output logic [1:0]  billete_denom_o,
  output logic        dispensando_o,
  output logic        dispenso_completo_o,
  output logic        error_monto_o,
  output logic        error_mecanismo_o,
  output logic [7:0]  contador_billetes_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, SELECT, ISSUE, WAIT_READY, DONE, FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   remaining_q, remaining_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    denom_q, denom_d;
  logic [7:0]    contador_q, contador_d;
  logic          stbHeld_q, stbHeld_d;
  logic          errMonto_q, errMonto_d;

  logic          stb;
  logic          montoInvalid;
  logic          timerExpired;
  logic [31:0]   denomValue;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      denom_q     <= 2'd0;
      contador_q  <= 8'd0;
      stbHeld_q   <= 1'b0;
      errMonto_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      denom_q     <= denom_d;
      contador_q  <= contador_d;
      stbHeld_q   <= stbHeld_d;
      errMonto_q  <= errMonto_d;
    end
  end

  always_comb begin
    denomValue = DENOM3;
    unique case (denom_q)
      2'd0:    denomValue = DENOM0;
      2'd1:    denomValue = DENOM1;
      2'd2:    denomValue = DENOM2;
      default: denomValue = DENOM3;
    endcase
  end

  assign montoInvalid = (remaining_q == 32'd0) || (remaining_q > MAX_MONTO) ||
                        ((remaining_q % DENOM3) != 32'd0);
  assign timerExpired = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    denom_d     = denom_q;
    contador_d  = contador_q;
    stbHeld_d   = 1'b0;
    errMonto_d  = 1'b0;
    stb         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (entregar_dinero_i) begin
          remaining_d = monto_i;
          contador_d  = 8'd0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (montoInvalid) begin
          errMonto_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q >= DENOM0)      denom_d = 2'd0;
        else if (remaining_q >= DENOM1) denom_d = 2'd1;
        else if (remaining_q >= DENOM2) denom_d = 2'd2;
        else                            denom_d = 2'd3;
        timer_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        // Once raised, the strobe stays up even if READY drops before the ACK.
        stb = mech_ready_i || stbHeld_q;
        if (stb && mech_ack_i) begin
          remaining_d = remaining_q - denomValue;
          contador_d  = (contador_q == 8'hFF) ? contador_q : contador_q + 8'd1;
          timer_d     = '0;
          state_d     = WAIT_READY;
        end else begin
          stbHeld_d = stb;
          if (timerExpired) state_d = FAULT;
          else              timer_d = timer_q + 1'b1;
        end
      end
      WAIT_READY: begin
        if (mech_ready_i) begin
          state_d = (remaining_q == 32'd0) ? DONE : SELECT;
        end else if (timerExpired) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign billete_stb_o       = stb;
  assign billete_denom_o     = denom_q;
  assign dispensando_o       = (state_q != IDLE) && (state_q != DONE);
  assign dispenso_completo_o = (state_q == DONE);
  assign error_monto_o       = errMonto_q;
  assign error_mecanismo_o   = (state_q == FAULT);
  assign contador_billetes_o = contador_q;

endmodule

// File: tb/tb_dispensador_billetes.sv
// Directed bench for dispensador_billetes: a simple mechanism model answers each
// strobe after a programmable delay, and per-order statistics are checked.
module tb_dispensador_billetes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        entregar_dinero_i;
  logic [31:0] monto_i;
  logic        mech_ready_i;
  logic        mech_ack_i;
  logic        billete_stb_o;
  logic [1:0]  billete_denom_o;
  logic        dispensando_o;
  logic        dispenso_completo_o;
  logic        error_monto_o;
  logic        error_mecanismo_o;
  logic [7:0]  contador_billetes_o;

  int vectorCount = 0;
  int missCount   = 0;

  int         stbCycles, completoCount, completoCycle, errCount, errCycle;
  int         faultCycle, faultDrop, unstable, extraCompleto;
  logic       dispFirst, dispAtDone;
  logic [1:0] denomLog[$];
  int         runLenLog[$];

  always #5 clk = ~clk;

  dispensador_billetes dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .entregar_dinero_i   (entregar_dinero_i),
    .monto_i             (monto_i),
    .mech_ready_i        (mech_ready_i),
    .mech_ack_i          (mech_ack_i),
    .billete_stb_o       (billete_stb_o),
    .billete_denom_o     (billete_denom_o),
    .dispensando_o       (dispensando_o),
    .dispenso_completo_o (dispenso_completo_o),
    .error_monto_o       (error_monto_o),
    .error_mecanismo_o   (error_mecanismo_o),
    .contador_billetes_o (contador_billetes_o)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic entregar, input logic [31:0] monto);
    entregar_dinero_i = entregar;
    monto_i           = monto;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".stb"},      32'(billete_stb_o),       32'd0);
    checkOutput({tag, ".denom"},    32'(billete_denom_o),     32'd0);
    checkOutput({tag, ".disp"},     32'(dispensando_o),       32'd0);
    checkOutput({tag, ".completo"}, 32'(dispenso_completo_o), 32'd0);
    checkOutput({tag, ".errMonto"}, 32'(error_monto_o),       32'd0);
    checkOutput({tag, ".errMec"},   32'(error_mecanismo_o),   32'd0);
    checkOutput({tag, ".contador"}, 32'(contador_billetes_o), 32'd0);
  endtask

  function automatic logic [31:0] denomAt(input int k);
    return (k < denomLog.size()) ? 32'(denomLog[k]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] runLenAt(input int k);
    return (k < runLenLog.size()) ? 32'(runLenLog[k]) : 32'hFFFF_FFFF;
  endfunction

  // Issues one order in cycle 0, then observes cycles 1..nCycles. The mechanism
  // acknowledges on the (ackDelay+1)-th consecutive strobe cycle of each bill.
  task automatic runOrder(input logic [31:0] monto, input int ackDelay, input int nCycles,
                          input int extraAt, input logic [31:0] extraMonto,
                          input int readyFrom);
    int         run = 0;
    logic [1:0] startDenom = 2'd0;
    stbCycles = 0; completoCount = 0; completoCycle = -1; errCount = 0; errCycle = -1;
    faultCycle = -1; faultDrop = 0; unstable = 0; dispFirst = 1'b0; dispAtDone = 1'b1;
    denomLog.delete();
    runLenLog.delete();
    nextCycle();
    applyStimulus(1'b1, monto);
    mech_ack_i   = 1'b0;
    mech_ready_i = (readyFrom == 0);
    for (int i = 1; i <= nCycles; i++) begin
      nextCycle();
      mech_ack_i   = 1'b0;
      mech_ready_i = (i >= readyFrom);
      if (i == extraAt) applyStimulus(1'b1, extraMonto);
      else              applyStimulus(1'b0, 32'hDEAD_BEEF);
      @(negedge clk);
      if (i == 1) dispFirst = dispensando_o;
      if (dispenso_completo_o) begin
        completoCount++;
        if (completoCycle < 0) begin
          completoCycle = i;
          dispAtDone    = dispensando_o;
        end
      end
      if (error_monto_o) begin
        errCount++;
        if (errCycle < 0) errCycle = i;
      end
      if (error_mecanismo_o) begin
        if (faultCycle < 0) faultCycle = i;
      end else if (faultCycle >= 0) begin
        faultDrop++;
      end
      if (billete_stb_o) begin
        stbCycles++;
        run++;
        if (run == 1) startDenom = billete_denom_o;
        else if (billete_denom_o != startDenom) unstable++;
        if (run == ackDelay + 1) begin
          mech_ack_i = 1'b1;
          denomLog.push_back(startDenom);
          runLenLog.push_back(run);
          run = 0;
        end
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    mech_ready_i = 1'b0;
    mech_ack_i   = 1'b0;
    applyStimulus(1'b0, 32'd0);
    #2;
    checkAllZero("reset");
    nextCycle();
    nextCycle();
    rst_n = 1'b1;

    $display("[TB] greedy split of 36000");
    runOrder(32'd36000, 0, 16, 0, 32'd0, 0);
    checkOutput("o36k.completoCycle", completoCycle, 32'd14);
    checkOutput("o36k.completoCount", completoCount, 32'd1);
    checkOutput("o36k.bills",         denomLog.size(), 32'd4);
    checkOutput("o36k.denom0",        denomAt(0), 32'd0);
    checkOutput("o36k.denom1",        denomAt(1), 32'd1);
    checkOutput("o36k.denom2",        denomAt(2), 32'd2);
    checkOutput("o36k.denom3",        denomAt(3), 32'd3);
    checkOutput("o36k.stbCycles",     stbCycles, 32'd4);
    checkOutput("o36k.contador",      32'(contador_billetes_o), 32'd4);
    checkOutput("o36k.dispFirst",     32'(dispFirst), 32'd1);
    checkOutput("o36k.dispAtDone",    32'(dispAtDone), 32'd0);
    checkOutput("o36k.errCount",      errCount, 32'd0);

    $display("[TB] rejected amounts");
    runOrder(32'd0, 0, 4, 0, 32'd0, 0);
    checkOutput("zero.errCount",  errCount, 32'd1);
    checkOutput("zero.errCycle",  errCycle, 32'd2);
    checkOutput("zero.stb",       stbCycles, 32'd0);
    checkOutput("zero.contador",  32'(contador_billetes_o), 32'd0);
    checkOutput("zero.disp",      32'(dispensando_o), 32'd0);
    runOrder(32'd1500, 0, 4, 0, 32'd0, 0);
    checkOutput("m1500.errCount", errCount, 32'd1);
    checkOutput("m1500.errCycle", errCycle, 32'd2);
    checkOutput("m1500.stb",      stbCycles, 32'd0);
    checkOutput("m1500.completo", completoCount, 32'd0);
    runOrder(32'd600000, 0, 4, 0, 32'd0, 0);
    checkOutput("big.errCount",   errCount, 32'd1);
    checkOutput("big.errCycle",   errCycle, 32'd2);
    checkOutput("big.stb",        stbCycles, 32'd0);
    checkOutput("big.disp",       32'(dispensando_o), 32'd0);

    $display("[TB] 40000 with ACK delayed 5 cycles");
    runOrder(32'd40000, 5, 20, 0, 32'd0, 0);
    checkOutput("o40k.bills",         denomLog.size(), 32'd2);
    checkOutput("o40k.denom0",        denomAt(0), 32'd0);
    checkOutput("o40k.denom1",        denomAt(1), 32'd0);
    checkOutput("o40k.runLen0",       runLenAt(0), 32'd6);
    checkOutput("o40k.runLen1",       runLenAt(1), 32'd6);
    checkOutput("o40k.unstable",      unstable, 32'd0);
    checkOutput("o40k.completoCycle", completoCycle, 32'd18);
    checkOutput("o40k.contador",      32'(contador_billetes_o), 32'd2);

    $display("[TB] mechanism never acknowledges");
    runOrder(32'd10000, 1000000, 1010, 1005, 32'd1000, 0);
    checkOutput("tmo.faultCycle", faultCycle, 32'd1003);
    checkOutput("tmo.faultDrop",  faultDrop, 32'd0);
    checkOutput("tmo.stbCycles",  stbCycles, 32'd1000);
    checkOutput("tmo.stbNow",     32'(billete_stb_o), 32'd0);
    checkOutput("tmo.disp",       32'(dispensando_o), 32'd1);
    checkOutput("tmo.completo",   completoCount, 32'd0);
    checkOutput("tmo.contador",   32'(contador_billetes_o), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkAllZero("tmoReset");
    nextCycle();
    rst_n = 1'b1;

    $display("[TB] reset in the middle of 25000");
    runOrder(32'd25000, 0, 4, 0, 32'd0, 0);
    checkOutput("mid.contadorBefore", 32'(contador_billetes_o), 32'd1);
    checkOutput("mid.denomBefore",    denomAt(0), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    extraCompleto = 0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      if (i == 2) rst_n = 1'b1;
      @(negedge clk);
      if (dispenso_completo_o || billete_stb_o) extraCompleto++;
    end
    checkOutput("mid.noCompletion", extraCompleto, 32'd0);
    runOrder(32'd5000, 0, 10, 0, 32'd0, 6);
    checkOutput("o5k.completoCycle", completoCycle, 32'd8);
    checkOutput("o5k.stbCycles",     stbCycles, 32'd1);
    checkOutput("o5k.denom0",        denomAt(0), 32'd2);
    checkOutput("o5k.contador",      32'(contador_billetes_o), 32'd1);

    $display("[TB] order ignored while busy");
    runOrder(32'd20000, 0, 12, 2, 32'd1000, 0);
    checkOutput("busy.bills",         denomLog.size(), 32'd1);
    checkOutput("busy.denom0",        denomAt(0), 32'd0);
    checkOutput("busy.completoCount", completoCount, 32'd1);
    checkOutput("busy.completoCycle", completoCycle, 32'd5);
    checkOutput("busy.contador",      32'(contador_billetes_o), 32'd1);
    checkOutput("busy.disp",          32'(dispensando_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/dispensador_billetes.md
Name: dispensador_billetes

Overview:
Bill-dispense sequencer placed between the ATM transaction controller and the cash mechanism. The controller issues a dispense order with ENTREGAR_DINERO and MONTO. This block splits the amount greedily into four denominations and drives the mechanism one bill at a time over a READY/STB/ACK handshake. It reports completion, invalid amounts, and mechanism timeouts back to the controller.

Parameters:
DENOM0, 20000, largest denomination (code 2'd0)
DENOM1, 10000, denomination code 2'd1
DENOM2, 5000, denomination code 2'd2
DENOM3, 1000, smallest denomination (code 2'd3); every valid MONTO is a multiple of it
MAX_MONTO, 500000, largest amount accepted per order
TIMEOUT, 1000, cycles allowed per handshake phase before a mechanism fault

Ports:
CLK  input  1  single clock; all state changes on the rising edge
RESET  input  1  asynchronous, active-low reset
ENTREGAR_DINERO  input  1  one-cycle dispense order; MONTO valid in the same cycle
MONTO  input  32  amount to dispense, unsigned
MECH_READY  input  1  mechanism can accept a bill command
MECH_ACK  input  1  mechanism has taken the bill in progress
BILLETE_STB  output  1  bill command valid; held until MECH_ACK
BILLETE_DENOM  output  2  denomination code of the bill in progress
DISPENSANDO  output  1  block busy
DISPENSO_COMPLETO  output  1  one-cycle pulse when the full amount has been dispensed
ERROR_MONTO  output  1  one-cycle pulse when the amount is rejected
ERROR_MECANISMO  output  1  sticky mechanism fault
CONTADOR_BILLETES  output  8  bills dispensed in the current or last order

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE. All outputs 0. Internal remaining-amount register and timeout counter cleared. Applies mid-operation: BILLETE_STB drops immediately and no completion or error pulse follows.
- States: IDLE, CHECK, SELECT, ISSUE, WAIT_READY, DONE, FAULT.
- IDLE: on ENTREGAR_DINERO=1, latch MONTO into the remaining register, clear CONTADOR_BILLETES, go to CHECK. DISPENSANDO=1 from the next cycle.
- CHECK (1 cycle): if remaining==0, remaining>MAX_MONTO, or remaining % DENOM3 != 0 (constant modulo), pulse ERROR_MONTO for exactly one cycle (the cycle after CHECK) and return to IDLE with no bill issued. Otherwise go to SELECT.
- SELECT (1 cycle): register the largest denomination with DENOMx <= remaining into BILLETE_DENOM, checked in the order DENOM0 to DENOM3. Go to ISSUE.
- ISSUE: if MECH_READY=1, assert BILLETE_STB. Hold BILLETE_STB and BILLETE_DENOM stable until a cycle with MECH_ACK=1. In that cycle: remaining -= selected denomination, CONTADOR_BILLETES += 1, go to WAIT_READY, and BILLETE_STB is 0 from the next cycle. A MECH_ACK received while BILLETE_STB=0 is ignored.
- WAIT_READY: wait for MECH_READY=1. Then go to DONE if remaining==0, else go to SELECT.
- DONE (1 cycle): DISPENSO_COMPLETO=1, DISPENSANDO=0 in the same cycle, next state IDLE.
- Timeout: the counter clears on entry to ISSUE and to WAIT_READY and increments each cycle spent there. When it reaches TIMEOUT, go to FAULT.
- FAULT: ERROR_MECANISMO=1, BILLETE_STB=0, DISPENSANDO=1. All orders are ignored. Only RESET leaves FAULT.
- ENTREGAR_DINERO outside IDLE is ignored; it is not queued. MONTO changes outside IDLE have no effect.
- CONTADOR_BILLETES saturates at 255 and keeps its value after DONE until the next accepted order.
- Arithmetic: remaining is 32-bit unsigned. Subtraction never underflows because the selected denomination is always <= remaining.
- Latency for a valid order, with MECH_READY=1 throughout and ACK in the first STB cycle: 1 (CHECK) + 3 per bill (SELECT, ISSUE, WAIT_READY) + 1 (DONE).

Test Plan:
- MONTO=36000, mechanism always ready, ACK in the first STB cycle -> BILLETE_DENOM sequence 0,1,2,3; CONTADOR_BILLETES=4; DISPENSO_COMPLETO pulses once, 14 cycles after the order.
- MONTO=0, then MONTO=1500, then MONTO=600000 -> each order gives a single ERROR_MONTO pulse, no BILLETE_STB, return to IDLE.
- MONTO=40000, MECH_ACK delayed 5 cycles per bill -> BILLETE_STB held 6 cycles per bill with stable DENOM=0; two bills; completion pulse.
- MONTO=10000, MECH_ACK never asserted, TIMEOUT=1000 -> ERROR_MECANISMO rises 1000 cycles after entering ISSUE and stays high; a further ENTREGAR_DINERO is ignored; RESET=0 clears it.
- MONTO=25000, RESET=0 pulse after the first ACK -> all outputs 0 immediately, no DISPENSO_COMPLETO; a new MONTO=5000 order then completes with CONTADOR_BILLETES=1.
- ENTREGAR_DINERO with MONTO=1000 pulsed while an order of MONTO=20000 is dispensing -> ignored; exactly one bill (DENOM=0) issued.
